// File: rtl/bridge_west_packer.sv
// bridge_west_packer: assembles NUM_INST*LANES stream words into one west-bank
// write vector, hands it off with valid/ready, and stalls after each tile of
// VECS_PER_TILE vectors until the consumer acknowledges the drain.
// Optional s_last consistency check: define BRIDGE_WEST_PACKER_LAST_CHECK_EN.
module bridge_west_packer #(
    parameter int unsigned NUM_INST      = 4,
    parameter int unsigned LANES         = 2,
    parameter int unsigned IN_WIDTH      = 64,
    parameter int unsigned VECS_PER_TILE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IN_WIDTH-1:0] s_data,
    input  logic                s_last,
    output logic [IN_WIDTH-1:0] dout [NUM_INST][LANES],
    output logic                out_valid,
    input  logic                dst_ready,
    output logic                tile_done,
    input  logic                tile_ack,
    output logic [$clog2(VECS_PER_TILE+1)-1:0] vec_cnt,
    output logic                err_last
);

    localparam int unsigned WORDS  = NUM_INST * LANES;
    localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CNT_W  = $clog2(VECS_PER_TILE + 1);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(VECS_PER_TILE);

    typedef enum logic [1:0] {StFill, StPresent, StWaitAck} state_e;

    state_e            st_q, st_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    // Word acceptance is gated only by state; s_ready additionally masks reset.
    assign accept  = s_valid && (st_q == StFill);
    assign vec_cnt = cnt_q;

    // Next-state, word index, tile counter and handshake outputs.
    always_comb begin
        st_d      = st_q;
        widx_d    = widx_q;
        cnt_d     = cnt_q;
        s_ready   = 1'b0;
        out_valid = 1'b0;
        tile_done = 1'b0;
        unique case (st_q)
            StFill: begin
                s_ready = rst_n;
                if (accept) begin
                    if (widx_q == LAST_IDX) begin
                        widx_d = '0;
                        st_d   = StPresent;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            StPresent: begin
                out_valid = 1'b1;
                if (dst_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    st_d  = (cnt_d == CNT_FULL) ? StWaitAck : StFill;
                end
            end
            StWaitAck: begin
                tile_done = 1'b1;
                if (tile_ack) begin
                    cnt_d = '0;
                    st_d  = StFill;
                end
            end
            default: st_d = StFill;
        endcase
    end

    // State, word index and vector counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= StFill;
            widx_q <= '0;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            widx_q <= widx_d;
            cnt_q  <= cnt_d;
        end
    end

    // Accepted words land directly in their output slot (instance-major, then lane).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_INST; i++) begin
                for (int j = 0; j < LANES; j++) begin
                    dout[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_INST; i++) begin
                for (int j = 0; j < LANES; j++) begin
                    if (widx_q == WIDX_W'(i * LANES + j)) begin
                        dout[i][j] <= s_data;
                    end
                end
            end
        end
    end

`ifdef BRIDGE_WEST_PACKER_LAST_CHECK_EN
    logic err_q;
    logic expected_last;

    assign expected_last = (widx_q == LAST_IDX) && (cnt_q == CNT_W'(VECS_PER_TILE - 1));
    assign err_last      = err_q;

    // Sticky flag: s_last must mark exactly the final word of a tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && (s_last != expected_last)) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_s_last;

    assign unused_s_last = s_last;
    assign err_last      = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_west_packer.sv
// Directed bench for bridge_west_packer at default parameters (8 words/vector,
// 8 vectors/tile). Define BRIDGE_WEST_PACKER_LAST_CHECK_EN to cover err_last.
module tb_bridge_west_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        s_last;
    logic [63:0] dout [4][2];
    logic        out_valid;
    logic        dst_ready;
    logic        tile_done;
    logic        tile_ack;
    logic [3:0]  vec_cnt;
    logic        err_last;

    int total = 0;
    int bad   = 0;

    bridge_west_packer #(
        .NUM_INST     (4),
        .LANES        (2),
        .IN_WIDTH     (64),
        .VECS_PER_TILE(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .dout     (dout),
        .out_valid(out_valid),
        .dst_ready(dst_ready),
        .tile_done(tile_done),
        .tile_ack (tile_ack),
        .vec_cnt  (vec_cnt),
        .err_last (err_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push 8 back-to-back words base..base+7; bit k of last_mask drives s_last on word k.
    task automatic send_vec(input logic [63:0] base, input logic [7:0] last_mask);
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_data  = base + 64'(k);
            s_last  = last_mask[k];
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_tile_done", 64'(tile_done), 64'd0);
        check("rst_vec_cnt", 64'(vec_cnt), 64'd0);
        check("rst_err_last", 64'(err_last), 64'd0);
        check("rst_dout00", dout[0][0], 64'd0);
        check("rst_dout31", dout[3][1], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_s_ready", 64'(s_ready), 64'd1);
    endtask

    initial begin
        int pulses;
        rst_n     = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        dst_ready = 1'b1;
        tile_ack  = 1'b0;
        #2;
        do_reset();

        // Single vector, dst_ready high.
        send_vec(64'h10, 8'h00);
        check("v1_out_valid", 64'(out_valid), 64'd1);
        check("v1_s_ready", 64'(s_ready), 64'd0);
        check("v1_dout00", dout[0][0], 64'h10);
        check("v1_dout01", dout[0][1], 64'h11);
        check("v1_dout20", dout[2][0], 64'h14);
        check("v1_dout31", dout[3][1], 64'h17);
        check("v1_cnt_pre", 64'(vec_cnt), 64'd0);
        step();
        check("v1_out_valid_drop", 64'(out_valid), 64'd0);
        check("v1_vec_cnt", 64'(vec_cnt), 64'd1);
        check("v1_s_ready_back", 64'(s_ready), 64'd1);

        // Reset after 3 words of vector 2; new vector must hold only new words.
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data  = 64'hA0 + 64'(k);
            step();
        end
        s_valid = 1'b0;
        do_reset();
        send_vec(64'h50, 8'h00);
        check("rv_out_valid", 64'(out_valid), 64'd1);
        check("rv_dout00", dout[0][0], 64'h50);
        check("rv_dout11", dout[1][1], 64'h53);
        check("rv_dout31", dout[3][1], 64'h57);
        step();
        check("rv_vec_cnt", 64'(vec_cnt), 64'd1);

        // Backpressure: hold 5 cycles, then one transfer.
        dst_ready = 1'b0;
        send_vec(64'h20, 8'h00);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_s_ready", 64'(s_ready), 64'd0);
            check("bp_dout20", dout[2][0], 64'h24);
            check("bp_vec_cnt", 64'(vec_cnt), 64'd1);
            step();
        end
        dst_ready = 1'b1;
        check("bp_last_hold", 64'(out_valid), 64'd1);
        step();
        check("bp_out_valid_drop", 64'(out_valid), 64'd0);
        check("bp_vec_cnt", 64'(vec_cnt), 64'd2);
        step();
        check("bp_single_xfer", 64'(vec_cnt), 64'd2);

        // Full tile with spurious acks in FILL and PRESENT.
        do_reset();
        pulses = 0;
        for (int v = 0; v < 8; v++) begin
            if (v == 2) begin
                tile_ack = 1'b1;
                step();
                tile_ack = 1'b0;
                check("spur_fill_cnt", 64'(vec_cnt), 64'd2);
                check("spur_fill_ready", 64'(s_ready), 64'd1);
                check("spur_fill_done", 64'(tile_done), 64'd0);
            end
            if (v == 4) dst_ready = 1'b0;
            send_vec(64'h100 + 64'(v * 8), (v == 7) ? 8'h80 : 8'h00);
            if (out_valid) pulses++;
            if (v == 4) begin
                tile_ack = 1'b1;
                step();
                tile_ack = 1'b0;
                check("spur_pres_valid", 64'(out_valid), 64'd1);
                check("spur_pres_cnt", 64'(vec_cnt), 64'd4);
                dst_ready = 1'b1;
            end
            step();
            check("tile_vec_cnt", 64'(vec_cnt), 64'(v + 1));
            check("tile_valid_drop", 64'(out_valid), 64'd0);
        end
        check("tile_pulses", 64'(pulses), 64'd8);
        check("tile_done_hi", 64'(tile_done), 64'd1);
        check("tile_s_ready", 64'(s_ready), 64'd0);
        check("tile_last_dout31", dout[3][1], 64'h13F);
        check("tile_err_last_ok", 64'(err_last), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("wait_done", 64'(tile_done), 64'd1);
            check("wait_cnt", 64'(vec_cnt), 64'd8);
        end
        tile_ack = 1'b1;
        step();
        tile_ack = 1'b0;
        check("ack_tile_done", 64'(tile_done), 64'd0);
        check("ack_s_ready", 64'(s_ready), 64'd1);
        check("ack_vec_cnt", 64'(vec_cnt), 64'd0);

        // Early s_last on word 7 of the first vector of a tile.
        send_vec(64'h200, 8'h80);
`ifdef BRIDGE_WEST_PACKER_LAST_CHECK_EN
        check("err_last_set", 64'(err_last), 64'd1);
`else
        check("err_last_tied", 64'(err_last), 64'd0);
`endif
        step();
        step();
`ifdef BRIDGE_WEST_PACKER_LAST_CHECK_EN
        check("err_last_held", 64'(err_last), 64'd1);
`else
        check("err_last_tied2", 64'(err_last), 64'd0);
`endif
        check("final_vec_cnt", 64'(vec_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
